// File: rtl/hash_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module : hash_gen_pkg
// Brief  : Shared constants, result record and rotate helper for the
//          multi-channel chained block hasher.
// Rev    : 1.0 - initial release
// ============================================================================
package hash_gen_pkg;

  // Control flags carried inside every input word
  localparam int BIT_BLOCK_START = 9;
  localparam int BIT_BLOCK_END   = 8;

  // Default geometry used by the packed result record
  localparam int HG_DATA_W = 128;
  localparam int HG_CH_W   = 2;

  typedef struct packed {
    logic [HG_CH_W-1:0]   ch;
    logic [HG_DATA_W-1:0] hash;
  } hash_res_t;

  // Left-rotate a default-width word by n bit positions (n wraps modulo width)
  function automatic logic [HG_DATA_W-1:0] rotl(input logic [HG_DATA_W-1:0] h,
                                                input int unsigned n);
    logic [2*HG_DATA_W-1:0] d;
    d = {h, h} << (n % HG_DATA_W);
    return d[2*HG_DATA_W-1 -: HG_DATA_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/hash_gen_mc_fifo.sv
`default_nettype none
// ============================================================================
// Module : hash_res_fifo
// Brief  : Show-ahead synchronous FIFO holding finished hash results; the
//          head entry is visible on o_dout whenever the FIFO is non-empty.
// Rev    : 1.0 - initial release
// ============================================================================
module hash_res_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage: cleared on reset so the head reads zero while empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers wrap at DEPTH so non-power-of-two depths work
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
    end
  end

  // Occupancy: simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/hash_gen_mc.sv
`default_nettype none
// ============================================================================
// Module : hash_gen_mc
// Brief  : Multi-channel chained block hasher. Each channel folds its words
//          as h = d ^ rotl(h, ROT); an END word queues {ch, hash} into an
//          output FIFO, whose fullness back-pressures the input.
// Rev    : 1.0 - initial release
// ============================================================================
module hash_gen_mc
  import hash_gen_pkg::*;
#(
  parameter  int DATA_W    = 128,
  parameter  int NUM_CH    = 4,
  parameter  int ROT       = 1,
  parameter  int OUT_DEPTH = 2,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CH_W-1:0]   ch_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CH_W-1:0]   ch_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              err_o
);

  localparam int CNT_W = $clog2(OUT_DEPTH + 1);

  logic [DATA_W-1:0]   r_hash [NUM_CH];
  logic [NUM_CH-1:0]   r_open;
  logic                r_err;

  logic                w_start;
  logic                w_end;
  logic                w_xfer;
  logic                w_orphan;
  logic [DATA_W-1:0]   w_prev;
  logic [2*DATA_W-1:0] w_dbl;
  logic [DATA_W-1:0]   w_rot;
  logic [DATA_W-1:0]   w_nh;
  logic [CNT_W-1:0]    w_count;
  logic                w_empty;
  logic                w_unused_full;

  assign w_start  = data_i[BIT_BLOCK_START];
  assign w_end    = data_i[BIT_BLOCK_END];
  // ready_o depends only on FIFO occupancy registers, never on ready_i
  assign ready_o  = (w_count < CNT_W'(OUT_DEPTH));
  assign w_xfer   = valid_i & ready_o;
  // A continuation word on a closed channel is flagged and restarts the hash
  assign w_orphan = ~w_start & ~r_open[ch_i];

  // Rotate-left via a doubled word: the upper DATA_W bits after shifting by ROT
  assign w_prev = r_hash[ch_i];
  assign w_dbl  = {w_prev, w_prev};
  assign w_rot  = w_dbl[2*DATA_W-1-ROT -: DATA_W];
  assign w_nh   = (w_start | w_orphan) ? data_i : (data_i ^ w_rot);

  assign valid_o = ~w_empty;
  assign err_o   = r_err;

  // Per-channel chaining state; only the addressed channel changes on a transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) r_hash[c] <= '0;
      r_open <= '0;
    end else if (w_xfer) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_i == CH_W'(c)) begin
          r_hash[c] <= w_nh;
          r_open[c] <= ~w_end;
        end
      end
    end
  end

  // One-cycle error pulse for an orphan continuation word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= w_xfer & w_orphan;
  end

  hash_res_fifo #(
    .WIDTH (CH_W + DATA_W),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_xfer & w_end),
    .i_din   ({ch_i, w_nh}),
    .i_pop   (ready_i),
    .o_dout  ({ch_o, data_o}),
    .o_count (w_count),
    .o_full  (w_unused_full),
    .o_empty (w_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_hash_gen_mc.sv
`default_nettype none
// ============================================================================
// Module : tb_hash_gen_mc
// Brief  : Directed self-checking bench for hash_gen_mc.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_hash_gen_mc;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] data_i = '0;
  logic [1:0]   ch_i = '0;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [127:0] data_o;
  logic [1:0]   ch_o;
  logic         valid_o;
  logic         ready_i = 1'b1;
  logic         err_o;

  int total = 0;
  int bad   = 0;

  hash_gen_mc dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .ch_i    (ch_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .ch_o    (ch_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one word, waiting (bounded) for ready_o; returns 1 ns after the accepting edge
  task automatic send(input logic [1:0] ch, input logic [127:0] d);
    int n;
    n = 0;
    while (!ready_o && n < 50) begin @(posedge clk); #1; n++; end
    if (!ready_o) begin
      total++; bad++;
      $display("FAIL send_timeout ready_o=%0b required=1", ready_o);
    end
    ch_i = ch; data_i = d; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", valid_o); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b exp=1", ready_o); end
    #20 rst_n = 1'b1;
    idle();
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b exp=0", err_o); end
    total++; if (data_o !== 128'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", data_o); end
    total++; if (ch_o !== 2'd0) begin bad++; $display("FAIL rst_ch got=%0d exp=0", ch_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid2 got=%0b exp=0", valid_o); end
  endtask

  task automatic test_single();
    send(2'd0, 128'h300);
    total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", valid_o); end
    total++; if (data_o !== 128'h300) begin bad++; $display("FAIL single_data got=%h exp=300", data_o); end
    total++; if (ch_o !== 2'd0) begin bad++; $display("FAIL single_ch got=%0d exp=0", ch_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL single_err got=%0b exp=0", err_o); end
    idle();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL single_pop got=%0b exp=0", valid_o); end
  endtask

  task automatic test_chain();
    send(2'd1, 128'h200);
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL chain_nopush got=%0b exp=0", valid_o); end
    send(2'd1, 128'h100);
    total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL chain_valid got=%0b exp=1", valid_o); end
    total++; if (data_o !== 128'h500) begin bad++; $display("FAIL chain_data got=%h exp=500", data_o); end
    total++; if (ch_o !== 2'd1) begin bad++; $display("FAIL chain_ch got=%0d exp=1", ch_o); end
    idle();
  endtask

  task automatic test_wrap();
    send(2'd0, 128'h8000_0000_0000_0000_0000_0000_0000_0200);
    send(2'd0, 128'h100);
    total++; if (data_o !== 128'h501) begin bad++; $display("FAIL wrap_data got=%h exp=501", data_o); end
    total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%0b exp=1", valid_o); end
    idle();
  endtask

  task automatic test_interleave();
    send(2'd0, 128'h200);
    send(2'd1, 128'h201);
    send(2'd0, 128'h100);
    total++; if (data_o !== 128'h500 || ch_o !== 2'd0)
      begin bad++; $display("FAIL ilv_first got=%0d:%h exp=0:500", ch_o, data_o); end
    send(2'd1, 128'h100);
    total++; if (data_o !== 128'h502 || ch_o !== 2'd1 || valid_o !== 1'b1)
      begin bad++; $display("FAIL ilv_second got=%0d:%h v=%0b exp=1:502 v=1", ch_o, data_o, valid_o); end
    idle();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL ilv_empty got=%0b exp=0", valid_o); end
  endtask

  task automatic test_back_to_back();
    ready_i = 1'b0;
    send(2'd0, 128'h311);
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL bp_ready1 got=%0b exp=1", ready_o); end
    send(2'd1, 128'h322);
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL bp_full got=%0b exp=0", ready_o); end
    ch_i = 2'd2; data_i = 128'h333; valid_i = 1'b1;
    idle(); idle();
    total++; if (data_o !== 128'h311 || ch_o !== 2'd0 || ready_o !== 1'b0)
      begin bad++; $display("FAIL bp_hold got=%0d:%h r=%0b exp=0:311 r=0", ch_o, data_o, ready_o); end
    ready_i = 1'b1;
    idle();
    total++; if (data_o !== 128'h322 || ch_o !== 2'd1 || ready_o !== 1'b1)
      begin bad++; $display("FAIL bp_drain1 got=%0d:%h r=%0b exp=1:322 r=1", ch_o, data_o, ready_o); end
    idle();
    valid_i = 1'b0;
    total++; if (data_o !== 128'h333 || ch_o !== 2'd2 || valid_o !== 1'b1)
      begin bad++; $display("FAIL bp_third got=%0d:%h v=%0b exp=2:333 v=1", ch_o, data_o, valid_o); end
    idle();
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0b exp=0", valid_o); end
  endtask

  task automatic test_restart();
    send(2'd1, 128'h200);
    send(2'd1, 128'h300);
    total++; if (data_o !== 128'h300 || err_o !== 1'b0)
      begin bad++; $display("FAIL restart got=%h err=%0b exp=300 err=0", data_o, err_o); end
    idle();
  endtask

  task automatic test_err_reset();
    send(2'd2, 128'h100);
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL orphan_err got=%0b exp=1", err_o); end
    total++; if (data_o !== 128'h100 || ch_o !== 2'd2)
      begin bad++; $display("FAIL orphan_data got=%0d:%h exp=2:100", ch_o, data_o); end
    idle();
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL orphan_pulse got=%0b exp=0", err_o); end
    ready_i = 1'b0;
    send(2'd0, 128'h300);
    send(2'd3, 128'h200);
    #2 rst_n = 1'b0;
    #1;
    total++; if (valid_o !== 1'b0 || ready_o !== 1'b1)
      begin bad++; $display("FAIL midrst got v=%0b r=%0b exp v=0 r=1", valid_o, ready_o); end
    ready_i = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    idle();
    send(2'd3, 128'h100);
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL postrst_err got=%0b exp=1", err_o); end
    total++; if (data_o !== 128'h100 || ch_o !== 2'd3)
      begin bad++; $display("FAIL postrst_data got=%0d:%h exp=3:100", ch_o, data_o); end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_chain();
    test_wrap();
    test_interleave();
    test_back_to_back();
    test_restart();
    test_err_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
